// File: rtl/sequencer_pkg.sv
// Shared definitions for the instruction sequencer: word width, opcode set
// and the sequencer FSM state encoding.
package sequencer_pkg;

  localparam int INSTR_W = 11;

  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_LDR  = 3'b001;
  localparam logic [2:0] OP_STR  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_ADDR = 3'b101;
  localparam logic [2:0] OP_SUBR = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_GAP_WAIT  = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_DONE      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/program_mem.sv
// Program store: synchronous write, asynchronous read, no reset so the
// loaded program survives a sequencer reset.
module program_mem
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a loaded program to a processor, either free-running with a fixed
// inter-issue gap or one instruction per step pulse.
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [AW:0]        prog_len,
  input  logic               step_mode,
  input  logic               start,
  input  logic               step,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               execute_next,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               load_err
);

  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  seq_state_t         r_state, w_state_n;
  logic [AW-1:0]      r_pc, w_pc_n;
  logic [AW:0]        r_cnt, w_cnt_n, r_len, w_len_n, w_cnt_inc;
  logic               r_step, w_step_n;
  logic [3:0]         r_gap, w_gap_n;
  logic [INSTR_W-1:0] r_instr, w_instr_n, w_rdata;
  logic               r_exec, w_exec_n;
  logic               r_load_err, w_load_err_n;
  logic               w_busy, w_issue, w_we;

  assign w_busy    = (r_state == S_RUN) || (r_state == S_GAP_WAIT) ||
                     (r_state == S_STEP_WAIT);
  assign w_we      = load_en && !w_busy;
  assign w_cnt_inc = r_cnt + (AW+1)'(1);

  program_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_step     <= 1'b0;
      r_gap      <= '0;
      r_instr    <= '0;
      r_exec     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_cnt      <= w_cnt_n;
      r_len      <= w_len_n;
      r_step     <= w_step_n;
      r_gap      <= w_gap_n;
      r_instr    <= w_instr_n;
      r_exec     <= w_exec_n;
      r_load_err <= w_load_err_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_cnt_n      = r_cnt;
    w_len_n      = r_len;
    w_step_n     = r_step;
    w_gap_n      = r_gap;
    w_instr_n    = r_instr;
    w_exec_n     = 1'b0;
    w_issue      = 1'b0;
    w_load_err_n = load_en && w_busy;

    // abort outranks everything, including a start or step on the same edge
    if (abort) begin
      w_state_n = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_len_n  = prog_len;
            w_step_n = step_mode;
            w_pc_n   = '0;
            w_cnt_n  = '0;
            if (prog_len == '0)  w_state_n = S_DONE;
            else if (step_mode)  w_state_n = S_STEP_WAIT;
            else                 w_state_n = S_RUN;
          end
        end
        S_RUN:       w_issue = 1'b1;
        S_GAP_WAIT: begin
          if (r_gap == GAP_LAST) w_state_n = S_RUN;
          else                   w_gap_n   = r_gap + 4'd1;
        end
        S_STEP_WAIT: w_issue = step;
        default:     w_state_n = S_IDLE;
      endcase
    end

    if (w_issue) begin
      w_instr_n = w_rdata;
      w_exec_n  = 1'b1;
      w_pc_n    = r_pc + AW'(1);
      w_cnt_n   = w_cnt_inc;
      if (w_cnt_inc == r_len) begin
        w_state_n = S_DONE;
      end else if (r_step) begin
        w_state_n = S_STEP_WAIT;
      end else if (GAP > 0) begin
        w_state_n = S_GAP_WAIT;
        w_gap_n   = '0;
      end else begin
        w_state_n = S_RUN;
      end
    end
  end

  assign instruction  = r_instr;
  assign execute_next = r_exec;
  assign pc           = r_pc;
  assign busy         = w_busy;
  assign done         = (r_state == S_DONE);
  assign load_err     = r_load_err;

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 16, program memory entries; power of two, 2..256.
REQ-002 SHALL have parameter GAP, 2, idle cycles between consecutive issues in run mode; 0..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port load_en  in  1  write load_data to program memory at load_addr.
REQ-007 SHALL have port load_addr  in  log2(DEPTH)  program memory write address.
REQ-008 SHALL have port load_data  in  11  instruction word: opcode[10:8], operand[7:0].
REQ-009 SHALL have port prog_len  in  log2(DEPTH)+1  number of instructions to issue, 0..DEPTH, sampled on start.
REQ-010 SHALL have port step_mode  in  1  sampled on start; 1 = issue only on step pulses.
REQ-011 SHALL have port start  in  1  begin program at address 0.
REQ-012 SHALL have port step  in  1  issue next instruction in step mode.
REQ-013 SHALL have port abort  in  1  stop issuing, return to IDLE.
REQ-014 SHALL have port instruction  out  11  registered word to the processor's instruction input.
REQ-015 SHALL have port execute_next  out  1  registered one-cycle issue strobe to the processor.
REQ-016 SHALL have port pc  out  log2(DEPTH)  address of the next instruction to issue.
REQ-017 SHALL have port busy  out  1  high in RUN, GAP_WAIT, STEP_WAIT.
REQ-018 SHALL have port done  out  1  high in DONE.
REQ-019 SHALL have port load_err  out  1  one-cycle pulse when load_en is rejected.

Function
REQ-020 SHALL implement states IDLE, RUN, GAP_WAIT, STEP_WAIT, DONE.
REQ-021 SHALL, in IDLE or DONE, on start: latch prog_len and step_mode, set pc=0 and issued count=0; prog_len=0 -> DONE; else step_mode=1 -> STEP_WAIT, step_mode=0 -> RUN.
REQ-022 SHALL, in RUN, issue one instruction: on that edge set instruction=mem[pc], execute_next=1, increment pc and count.
REQ-023 SHALL, after an issue, go to DONE if count equals prog_len; otherwise go to GAP_WAIT (run mode, GAP>0), RUN (GAP=0) or STEP_WAIT (step mode).
REQ-024 SHALL stay in GAP_WAIT for exactly GAP cycles, then return to RUN; consecutive execute_next pulses are GAP+1 cycles apart.
REQ-025 SHALL, in STEP_WAIT, perform the RUN issue on an edge where step=1, with the same next-state rule; step is ignored in all other states.
REQ-026 SHALL drive execute_next high for exactly one cycle per issue and never in two consecutive cycles unless GAP=0.
REQ-027 SHALL hold instruction at the last issued value between issues and after DONE.
REQ-028 SHALL take the first execute_next the cycle after start is sampled in run mode: start at edge k -> execute_next high after edge k+1.
REQ-029 SHALL wrap pc to 0 after DEPTH-1; issue count limits execution to prog_len.
REQ-030 SHALL apply priority reset > abort > start > step; abort in any state -> IDLE next edge with no further execute_next; start while busy is ignored.
REQ-031 SHALL accept load_en only in IDLE or DONE (write on that edge); while busy the write is dropped and load_err pulses one cycle.
REQ-032 SHALL read program memory combinationally, so a write at edge k is visible to an issue at edge k+1.

Reset
REQ-033 SHALL on reset set state=IDLE, pc=0, count=0, instruction=0, execute_next=0, busy=0, done=0, load_err=0; reset mid-run suppresses any pending issue.
REQ-034 SHALL not clear program memory on reset.

Structure
REQ-035 SHALL place INSTR_W=11, opcode constants (LDI 000, LDR 001, STR 010, ADDI 011, SUBI 100, ADDR 101, SUBR 110, OUT 111) and the state encoding in shared package sequencer_pkg.
REQ-036 SHALL instantiate one sub-module program_mem (DEPTH x 11, synchronous write, asynchronous read).

Verification
REQ-037 SHALL verify run mode: load 000_00000101, 011_00000011, 111_00000000, prog_len=3, GAP=2, start -> three execute_next pulses 3 cycles apart with those words, pc 1,2,3, then done=1.
REQ-038 SHALL verify prog_len=0, start -> done=1 next cycle, no execute_next.
REQ-039 SHALL verify step mode, prog_len=2: no issue until step; two step pulses 5 cycles apart -> exactly two execute_next, third step ignored, done=1.
REQ-040 SHALL verify abort one cycle after the first issue of a 4-instruction run -> IDLE, busy=0, no further execute_next.
REQ-041 SHALL verify load_en during busy -> load_err pulse, mem unchanged (re-run issues original word).
REQ-042 SHALL verify reset asserted in GAP_WAIT -> all outputs at reset values next cycle, program memory contents retained.
